// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared opcodes, pc_control encodings and fetch FSM states
package fetch_sequencer_pkg;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_BRANCH  = 6'h04;
    localparam logic [5:0] OPC_HALT    = 6'h3F;
    localparam logic [5:0] FUNCT_JR    = 6'h08;

    localparam logic [3:0] PCC_SEQ     = 4'b0000;
    localparam logic [3:0] PCC_JR      = 4'b0001;
    localparam logic [3:0] PCC_J       = 4'b0010;
    localparam logic [3:0] PCC_BRANCH  = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALT   = 3'd4,
        ST_FAULT  = 3'd5
    } fetch_state_t;

    // PC update select for a retiring instruction; not-taken branches fall through
    function automatic logic [3:0] decode_pc_control(
        input logic [5:0] opcode,
        input logic [5:0] funct,
        input logic       br_taken
    );
        logic [3:0] pcc;
        pcc = PCC_SEQ;
        if (opcode == OPC_J) begin
            pcc = PCC_J;
        end else if ((opcode == OPC_SPECIAL) && (funct == FUNCT_JR)) begin
            pcc = PCC_JR;
        end else if ((opcode == OPC_BRANCH) && br_taken) begin
            pcc = PCC_BRANCH;
        end
        return pcc;
    endfunction

endpackage

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - imem wait-cycle counter, flags the last allowed FETCH cycle
module fetch_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_count_en,
    output logic o_expire
);

    // The count reaches TIMEOUT on the edge that leaves the last allowed cycle
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    // Count while fetching; any other state holds the counter cleared for the next entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_count_en) begin
            r_count <= r_count + 8'd1;
        end else begin
            r_count <= 8'd0;
        end
    end

    assign o_expire = i_count_en && (r_count == LP_LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - single-issue fetch/execute/update sequencer with halt and fetch timeout
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int         TIMEOUT  = 255,
    parameter logic [5:0] HALT_OPC = OPC_HALT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        ex_done,
    input  logic        br_taken,
    output logic [4:0]  rs_addr,
    input  logic [31:0] rs_data,
    output logic        pc_en,
    output logic [3:0]  pc_control,
    output logic [25:0] jump_address,
    output logic [15:0] branch_offset,
    output logic [31:0] reg_address,
    output logic        halted,
    output logic        fault
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic [3:0]  r_pc_control;
    logic [31:0] r_reg_address;

    logic        w_expire;
    logic        w_fetching;
    logic        w_accept;
    logic        w_retire;
    logic        w_is_halt;

    assign w_is_halt = (r_instr[31:26] == HALT_OPC);

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk        (clk),
        .rst        (rst),
        .i_count_en (w_fetching),
        .o_expire   (w_expire)
    );

    // State register; reset parks in IDLE so the first fetch starts one clock after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and state-decoded outputs; an ack wins over a same-cycle timeout
    always_comb begin
        w_state_next = r_state;
        w_fetching   = 1'b0;
        w_accept     = 1'b0;
        w_retire     = 1'b0;
        imem_req     = 1'b0;
        imem_addr    = 32'd0;
        pc_en        = 1'b0;
        pc_control   = PCC_SEQ;
        halted       = 1'b0;
        fault        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req   = 1'b1;
                imem_addr  = pc;
                w_fetching = 1'b1;
                if (imem_ack) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_EXEC;
                end else if (w_expire) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_EXEC: begin
                if (ex_done) begin
                    w_retire     = 1'b1;
                    w_state_next = w_is_halt ? ST_HALT : ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                pc_en        = 1'b1;
                pc_control   = r_pc_control;
                w_state_next = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Instruction register and the decisions captured when execute retires the instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr       <= 32'd0;
            r_instr_valid <= 1'b0;
            r_pc_control  <= PCC_SEQ;
            r_reg_address <= 32'd0;
        end else begin
            if (w_accept) begin
                r_instr       <= imem_rdata;
                r_instr_valid <= 1'b1;
            end
            if (w_retire) begin
                r_instr_valid <= 1'b0;
                r_pc_control  <= w_is_halt ? PCC_SEQ
                                           : decode_pc_control(r_instr[31:26], r_instr[5:0], br_taken);
                r_reg_address <= rs_data;
            end
        end
    end

    assign instr         = r_instr;
    assign instr_valid   = r_instr_valid;
    assign reg_address   = r_reg_address;
    assign rs_addr       = r_instr[25:21];
    assign jump_address  = r_instr[25:0];
    assign branch_offset = r_instr[15:0];

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ex_done;
    logic        br_taken;
    logic [4:0]  rs_addr;
    logic [31:0] rs_data;
    logic        pc_en;
    logic [3:0]  pc_control;
    logic [25:0] jump_address;
    logic [15:0] branch_offset;
    logic [31:0] reg_address;
    logic        halted;
    logic        fault;

    fetch_sequencer #(
        .TIMEOUT  (4),
        .HALT_OPC (6'h3F)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .ex_done       (ex_done),
        .br_taken      (br_taken),
        .rs_addr       (rs_addr),
        .rs_data       (rs_data),
        .pc_en         (pc_en),
        .pc_control    (pc_control),
        .jump_address  (jump_address),
        .branch_offset (branch_offset),
        .reg_address   (reg_address),
        .halted        (halted),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] pc_model;

    typedef struct {
        logic [31:0] word;
        int          lat;
        int          ex;
        logic [31:0] rs;
        logic        br;
        logic [3:0]  pcc;
        logic        halt;
    } vec_t;

    vec_t tbl [0:8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decode from the instruction-set rules
    function automatic logic [3:0] ref_pcc(input logic [31:0] w, input logic br);
        logic [5:0] opc;
        logic [5:0] fn;
        opc = w[31:26];
        fn  = w[5:0];
        if (opc == 6'h02) return 4'b0010;
        if (opc == 6'h00 && fn == 6'h08) return 4'b0001;
        if (opc == 6'h04 && br) return 4'b0011;
        return 4'b0000;
    endfunction

    // Program counter behaviour the sequencer is steering
    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic [31:0] w,
                                                input logic [3:0] pcc, input logic [31:0] rs);
        logic [31:0] seq;
        logic [31:0] off;
        seq = cur + 32'd4;
        off = {{14{w[15]}}, w[15:0], 2'b00};
        case (pcc)
            4'b0010: return {seq[31:28], w[25:0], 2'b00};
            4'b0001: return rs;
            4'b0011: return seq + off;
            default: return seq;
        endcase
    endfunction

    task automatic check_all_zero();
        chk("rst imem_req", 32'(imem_req), 32'd0);
        chk("rst imem_addr", imem_addr, 32'd0);
        chk("rst instr", instr, 32'd0);
        chk("rst instr_valid", 32'(instr_valid), 32'd0);
        chk("rst pc_en", 32'(pc_en), 32'd0);
        chk("rst pc_control", 32'(pc_control), 32'd0);
        chk("rst reg_address", reg_address, 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst fault", 32'(fault), 32'd0);
        chk("rst rs_addr", 32'(rs_addr), 32'd0);
        chk("rst jump_address", 32'(jump_address), 32'd0);
        chk("rst branch_offset", 32'(branch_offset), 32'd0);
    endtask

    // Assert reset (outputs must clear at once), feed a stale ack, release, land in FETCH
    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        ex_done = 1'b0;
        br_taken = 1'b0;
        #1;
        check_all_zero();
        @(posedge clk);
        #1;
        imem_ack = 1'b1;
        imem_rdata = $urandom;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pc_model = 32'h100;
        pc = pc_model;
        chk("idle imem_req", 32'(imem_req), 32'd0);
        step();
        imem_ack = 1'b0;
        chk("post-idle imem_req", 32'(imem_req), 32'd1);
        chk("post-idle imem_addr", imem_addr, 32'h100);
        chk("stale ack instr_valid", 32'(instr_valid), 32'd0);
        chk("stale ack instr", instr, 32'd0);
    endtask

    // One instruction through FETCH/EXEC/UPDATE (or HALT); entered in the first FETCH cycle
    task automatic run_instr(input logic [31:0] word, input int lat, input int ex,
                             input logic [31:0] rs, input logic br,
                             input logic [3:0] exp_pcc, input logic exp_halt);
        imem_rdata = $urandom;
        for (int c = 1; c <= lat; c++) begin
            chk("fetch imem_req", 32'(imem_req), 32'd1);
            chk("fetch imem_addr", imem_addr, pc_model);
            chk("fetch pc_en", 32'(pc_en), 32'd0);
            if (c == lat) begin
                imem_ack = 1'b1;
                imem_rdata = word;
            end
            step();
            imem_ack = 1'b0;
            imem_rdata = $urandom;
        end
        chk("exec fault", 32'(fault), 32'd0);
        chk("exec imem_req", 32'(imem_req), 32'd0);
        chk("exec rs_addr", 32'(rs_addr), 32'(word[25:21]));
        chk("exec jump_address", 32'(jump_address), 32'(word[25:0]));
        chk("exec branch_offset", 32'(branch_offset), 32'(word[15:0]));
        for (int e = 1; e <= ex; e++) begin
            chk("exec instr", instr, word);
            chk("exec instr_valid", 32'(instr_valid), 32'd1);
            chk("exec pc_en", 32'(pc_en), 32'd0);
            ex_done = (e == ex);
            br_taken = (e == ex) ? br : 1'($urandom_range(0, 1));
            rs_data = (e == ex) ? rs : $urandom;
            imem_ack = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            step();
        end
        ex_done = 1'b0;
        br_taken = 1'b0;
        imem_ack = 1'b0;
        rs_data = $urandom;
        chk("retire instr_valid", 32'(instr_valid), 32'd0);
        chk("retire imem_req", 32'(imem_req), 32'd0);
        if (exp_halt) begin
            chk("halt halted", 32'(halted), 32'd1);
            chk("halt pc_en", 32'(pc_en), 32'd0);
            imem_ack = 1'b1;
            step();
            step();
            imem_ack = 1'b0;
            chk("halt sticky", 32'(halted), 32'd1);
            chk("halt imem_req", 32'(imem_req), 32'd0);
            chk("halt pc_en late", 32'(pc_en), 32'd0);
            chk("halt fault", 32'(fault), 32'd0);
        end else begin
            chk("update pc_en", 32'(pc_en), 32'd1);
            chk("update pc_control", 32'(pc_control), 32'(exp_pcc));
            chk("update reg_address", reg_address, rs);
            chk("update jump_address", 32'(jump_address), 32'(word[25:0]));
            pc_model = ref_next_pc(pc_model, word, exp_pcc, rs);
            pc = pc_model;
            step();
            chk("refetch pc_en", 32'(pc_en), 32'd0);
            chk("refetch pc_control", 32'(pc_control), 32'd0);
        end
    endtask

    // No ack for TIMEOUT=4 FETCH cycles: fault then stays put
    task automatic run_timeout();
        for (int c = 1; c <= 4; c++) begin
            chk("timeout imem_req", 32'(imem_req), 32'd1);
            chk("timeout early fault", 32'(fault), 32'd0);
            step();
        end
        chk("timeout fault", 32'(fault), 32'd1);
        chk("timeout imem_req off", 32'(imem_req), 32'd0);
        chk("timeout pc_en", 32'(pc_en), 32'd0);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
        chk("fault sticky", 32'(fault), 32'd1);
        chk("fault imem_req", 32'(imem_req), 32'd0);
        chk("fault instr_valid", 32'(instr_valid), 32'd0);
        chk("fault halted", 32'(halted), 32'd0);
    endtask

    initial begin
        int unsigned r;
        int          k;
        logic [31:0] w;
        logic        b;

        rst = 1'b1;
        pc = 32'h100;
        pc_model = 32'h100;
        imem_ack = 1'b0;
        imem_rdata = 32'd0;
        ex_done = 1'b0;
        br_taken = 1'b0;
        rs_data = 32'd0;

        tbl[0] = '{32'h2000_0000, 3, 1, 32'h0000_0000, 1'b0, 4'b0000, 1'b0};
        tbl[1] = '{32'h0800_0040, 1, 2, 32'h1111_2222, 1'b1, 4'b0010, 1'b0};
        tbl[2] = '{32'h03E0_0008, 2, 1, 32'hDEAD_0000, 1'b0, 4'b0001, 1'b0};
        tbl[3] = '{32'h1000_FFFE, 1, 1, 32'h0000_0000, 1'b1, 4'b0011, 1'b0};
        tbl[4] = '{32'h1000_FFFE, 2, 3, 32'h0000_0000, 1'b0, 4'b0000, 1'b0};
        tbl[5] = '{32'h0000_0020, 4, 1, 32'h0000_0004, 1'b0, 4'b0000, 1'b0};
        tbl[6] = '{32'h0C00_0008, 1, 1, 32'hA5A5_5A5A, 1'b1, 4'b0000, 1'b0};
        tbl[7] = '{32'h0200_0008, 3, 2, 32'h1234_5678, 1'b1, 4'b0001, 1'b0};
        tbl[8] = '{32'hFC00_0000, 2, 1, 32'h0000_0000, 1'b0, 4'b0000, 1'b1};

        do_reset();
        for (int i = 0; i <= 8; i++) begin
            run_instr(tbl[i].word, tbl[i].lat, tbl[i].ex, tbl[i].rs, tbl[i].br,
                      tbl[i].pcc, tbl[i].halt);
            if (i == 0) chk("seq next imem_addr", imem_addr, 32'h104);
        end

        do_reset();
        run_timeout();

        do_reset();
        step();
        #2;
        do_reset();

        for (int n = 0; n < 150; n++) begin
            r = $urandom;
            k = $urandom_range(0, 9);
            case (k)
                0, 1:    w = {6'h02, r[25:0]};
                2:       w = {6'h00, r[25:6], 6'h08};
                3, 4:    w = {6'h04, r[25:0]};
                5:       w = {6'h3F, r[25:0]};
                default: w = r;
            endcase
            b = 1'($urandom_range(0, 1));
            if (k == 6) begin
                run_timeout();
                do_reset();
            end else if (k == 7) begin
                for (int c = 0; c < $urandom_range(0, 3); c++) step();
                #2;
                do_reset();
            end else begin
                run_instr(w, $urandom_range(1, 4), $urandom_range(1, 3), $urandom, b,
                          ref_pcc(w, b), w[31:26] == 6'h3F);
                if (w[31:26] == 6'h3F) do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
